// File: rtl/aes_sbox_pkg.sv
// aes_sbox_pkg: FIPS-197 S-box tables, engine state encoding and byte type.
// The inverse table exists only when SBOX_INV_EN is defined.
package aes_sbox_pkg;

    typedef logic [7:0] byteT;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } stateT;

    localparam byteT SBOX_FWD [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

`ifdef SBOX_INV_EN
    localparam byteT SBOX_INV [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };
`endif

endpackage

// File: rtl/sub_bytes_engine_if.sv
// sub_bytes_engine_if: input and output valid/ready channels of the SubBytes engine.
// master = producer/consumer side, slave = engine side.
interface sub_bytes_engine_if #(
    parameter int WORD_BYTES = 16
);
    logic                    in_valid;
    logic                    in_ready;
    logic [8*WORD_BYTES-1:0] in_data;
    logic                    in_inv;
    logic                    out_valid;
    logic                    out_ready;
    logic [8*WORD_BYTES-1:0] out_data;

    modport master (
        output in_valid, in_data, in_inv, out_ready,
        input  in_ready, out_valid, out_data
    );

    modport slave (
        input  in_valid, in_data, in_inv, out_ready,
        output in_ready, out_valid, out_data
    );
endinterface

// File: rtl/sub_bytes_engine_sbox_lut.sv
// sbox_lut: one-byte combinational S-box lookup.
// With SBOX_INV_EN defined the inverse table is built and inv selects it;
// otherwise only the forward table exists and inv is ignored.
module sbox_lut
    import aes_sbox_pkg::*;
(
    input  byteT byte_in,
    input  logic inv,
    output byteT byte_out
);

`ifdef SBOX_INV_EN
    assign byte_out = inv ? SBOX_INV[byte_in] : SBOX_FWD[byte_in];
`else
    logic unusedInv;
    assign unusedInv = inv;
    assign byte_out  = SBOX_FWD[byte_in];
`endif

endmodule

// File: rtl/sub_bytes_engine.sv
// sub_bytes_engine: multi-cycle AES SubBytes, LANES bytes substituted per clock.
// Optional inverse substitution is built when SBOX_INV_EN is defined.
//
//   state | meaning
//   IDLE  | ready for a new word (in_ready=1 once out of reset)
//   RUN   | substituting chunk chunkCnt of the latched word
//   DONE  | result held on out_data with out_valid=1 until out_ready
module sub_bytes_engine
    import aes_sbox_pkg::*;
#(
    parameter int WORD_BYTES = 16,
    parameter int LANES      = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    sub_bytes_engine_if.slave  bus,
    output logic               busy
);

    localparam int NCHUNK     = WORD_BYTES / LANES;
    localparam int CNT_W      = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam int CHUNK_BITS = 8 * LANES;
    localparam int WORD_BITS  = 8 * WORD_BYTES;

    if ((LANES < 1) || ((WORD_BYTES % LANES) != 0)) begin : gLanesCheck
        $fatal(1, "sub_bytes_engine: LANES must divide WORD_BYTES");
    end

    stateT                  state;
    logic [CNT_W-1:0]       chunkCnt;
    logic [WORD_BITS-1:0]   wordReg;
    logic [WORD_BITS-1:0]   resultReg;
    logic                   inReadyReg;
    logic                   outValidReg;
    logic                   busyReg;
    logic                   invSel;
    logic [CHUNK_BITS-1:0]  laneInFlat;
    logic [CHUNK_BITS-1:0]  laneOutFlat;

`ifdef SBOX_INV_EN
    logic invReg;
    assign invSel = invReg;
`else
    logic unusedInInv;
    assign unusedInInv = bus.in_inv;
    assign invSel      = 1'b0;
`endif

    // Route the chunk addressed by the counter into the lookup lanes.
    always_comb begin
        laneInFlat = '0;
        for (int c = 0; c < NCHUNK; c++) begin
            if (chunkCnt == CNT_W'(c)) begin
                laneInFlat = wordReg[c*CHUNK_BITS +: CHUNK_BITS];
            end
        end
    end

    for (genvar l = 0; l < LANES; l++) begin : gLane
        sbox_lut uLut (
            .byte_in  (laneInFlat[8*l +: 8]),
            .inv      (invSel),
            .byte_out (laneOutFlat[8*l +: 8])
        );
    end

    // Handshake FSM, chunk counter and result assembly; all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            chunkCnt    <= '0;
            wordReg     <= '0;
            resultReg   <= '0;
            inReadyReg  <= 1'b0;
            outValidReg <= 1'b0;
            busyReg     <= 1'b0;
`ifdef SBOX_INV_EN
            invReg      <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    inReadyReg <= 1'b1;
                    if (bus.in_valid && inReadyReg) begin
                        wordReg    <= bus.in_data;
`ifdef SBOX_INV_EN
                        invReg     <= bus.in_inv;
`endif
                        chunkCnt   <= '0;
                        inReadyReg <= 1'b0;
                        busyReg    <= 1'b1;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    for (int c = 0; c < NCHUNK; c++) begin
                        if (chunkCnt == CNT_W'(c)) begin
                            resultReg[c*CHUNK_BITS +: CHUNK_BITS] <= laneOutFlat;
                        end
                    end
                    if (chunkCnt == CNT_W'(NCHUNK - 1)) begin
                        chunkCnt    <= '0;
                        outValidReg <= 1'b1;
                        state       <= DONE;
                    end else begin
                        chunkCnt <= chunkCnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.out_ready) begin
                        outValidReg <= 1'b0;
                        busyReg     <= 1'b0;
                        inReadyReg  <= 1'b1;
                        state       <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready  = inReadyReg;
    assign bus.out_valid = outValidReg;
    assign bus.out_data  = resultReg;
    assign busy          = busyReg;

endmodule

// File: tb/tb_sub_bytes_engine.sv
// tb_sub_bytes_engine: directed vectors driven in parallel into three engines
// (LANES = 4, 16, 1 with WORD_BYTES = 16) sharing the same input stimulus.
module tb_sub_bytes_engine;

    logic         clk;
    logic         rstN;
    logic         inValid;
    logic [127:0] inData;
    logic         inInv;
    logic         outReady;
    logic         busy4, busy16, busy1;
    int           nChecks;
    int           nFails;
    int           xfer4;

    sub_bytes_engine_if #(.WORD_BYTES(16)) b4 ();
    sub_bytes_engine_if #(.WORD_BYTES(16)) b16 ();
    sub_bytes_engine_if #(.WORD_BYTES(16)) b1 ();

    assign b4.in_valid   = inValid;
    assign b4.in_data    = inData;
    assign b4.in_inv     = inInv;
    assign b4.out_ready  = outReady;
    assign b16.in_valid  = inValid;
    assign b16.in_data   = inData;
    assign b16.in_inv    = inInv;
    assign b16.out_ready = outReady;
    assign b1.in_valid   = inValid;
    assign b1.in_data    = inData;
    assign b1.in_inv     = inInv;
    assign b1.out_ready  = outReady;

    sub_bytes_engine #(.WORD_BYTES(16), .LANES(4))  dut4  (.clk(clk), .rst_n(rstN), .bus(b4),  .busy(busy4));
    sub_bytes_engine #(.WORD_BYTES(16), .LANES(16)) dut16 (.clk(clk), .rst_n(rstN), .bus(b16), .busy(busy16));
    sub_bytes_engine #(.WORD_BYTES(16), .LANES(1))  dut1  (.clk(clk), .rst_n(rstN), .bus(b1),  .busy(busy1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count output handshakes of the LANES=4 engine.
    always @(posedge clk) begin
        if (b4.out_valid && outReady) xfer4 <= xfer4 + 1;
    end

    task automatic checkEq(input string tag, input logic [127:0] got, input logic [127:0] exp);
        nChecks++;
        if (got !== exp) begin
            nFails++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic sendWord(input logic [127:0] d, input logic inv);
        int n;
        n = 0;
        @(negedge clk);
        while (!(b4.in_ready && b16.in_ready && b1.in_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        checkEq("send ready", 128'(b4.in_ready && b16.in_ready && b1.in_ready), 128'(1));
        inData  = d;
        inInv   = inv;
        inValid = 1'b1;
        @(posedge clk);
        #1;
        inValid = 1'b0;
        inData  = ~d;
        inInv   = ~inv;
    endtask

    // Called right after the accept edge with outReady high; k counts edges after it.
    task automatic collectWord(input logic [127:0] expData, input string tag);
        int lat4, lat16, lat1;
        lat4 = -1; lat16 = -1; lat1 = -1;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk);
            @(negedge clk);
            if (k == 1) begin
                checkEq({tag, " busy4 run"}, 128'(busy4), 128'(1));
                checkEq({tag, " ready4 run"}, 128'(b4.in_ready), 128'(0));
            end
            if (b4.out_valid && lat4 < 0) begin
                lat4 = k;
                checkEq({tag, " data4"}, b4.out_data, expData);
            end else if (lat4 > 0 && k == lat4 + 1) begin
                checkEq({tag, " ready4 after"}, 128'(b4.in_ready), 128'(1));
                checkEq({tag, " valid4 drop"}, 128'(b4.out_valid), 128'(0));
            end
            if (b16.out_valid && lat16 < 0) begin
                lat16 = k;
                checkEq({tag, " data16"}, b16.out_data, expData);
            end else if (lat16 > 0 && k == lat16 + 1) begin
                checkEq({tag, " ready16 after"}, 128'(b16.in_ready), 128'(1));
            end
            if (b1.out_valid && lat1 < 0) begin
                lat1 = k;
                checkEq({tag, " data1"}, b1.out_data, expData);
            end else if (lat1 > 0 && k == lat1 + 1) begin
                checkEq({tag, " ready1 after"}, 128'(b1.in_ready), 128'(1));
            end
        end
        checkEq({tag, " latency4"}, 128'(lat4), 128'(4));
        checkEq({tag, " latency16"}, 128'(lat16), 128'(1));
        checkEq({tag, " latency1"}, 128'(lat1), 128'(16));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] vZero, eZero, vMix, eMix, vInvA, eInvA, vInvB, eInvB;
        int n;
        int xferBefore;

        nChecks = 0; nFails = 0; xfer4 = 0;
        rstN = 1'b0; inValid = 1'b0; inData = '0; inInv = 1'b0; outReady = 1'b1;

        vZero = '0;
        eZero = {16{8'h63}};
        vMix = {16{8'h01}};
        vMix[7:0] = 8'h53; vMix[15:8] = 8'h00; vMix[127:120] = 8'hff;
        eMix = {16{8'h7c}};
        eMix[7:0] = 8'hed; eMix[15:8] = 8'h63; eMix[127:120] = 8'h16;
        vInvA = {16{8'h63}};
        vInvB = {16{8'h63}};
        vInvB[7:0] = 8'hed;
`ifdef SBOX_INV_EN
        eInvA = '0;
        eInvB = '0;
        eInvB[7:0] = 8'h53;
`else
        eInvA = {16{8'hfb}};
        eInvB = {16{8'hfb}};
        eInvB[7:0] = 8'h55;
`endif

        // Reset values.
        repeat (3) @(negedge clk);
        checkEq("rst valid4", 128'(b4.out_valid), 128'(0));
        checkEq("rst data4", b4.out_data, 128'(0));
        checkEq("rst busy4", 128'(busy4), 128'(0));
        checkEq("rst ready4", 128'(b4.in_ready), 128'(0));
        checkEq("rst valid16", 128'(b16.out_valid), 128'(0));
        checkEq("rst valid1", 128'(b1.out_valid), 128'(0));
        rstN = 1'b1;

        sendWord(vZero, 1'b0);
        collectWord(eZero, "zero");
        sendWord(vMix, 1'b0);
        collectWord(eMix, "mixed");
        sendWord(vInvA, 1'b1);
        collectWord(eInvA, "invA");
        sendWord(vInvB, 1'b1);
        collectWord(eInvB, "invB");

        // Backpressure: hold DONE for 10 cycles after out_valid rises.
        outReady = 1'b0;
        sendWord(vMix, 1'b0);
        n = 0;
        while (!b4.out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkEq("bp valid rise", 128'(b4.out_valid), 128'(1));
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checkEq("bp valid held", 128'(b4.out_valid), 128'(1));
            checkEq("bp data held", b4.out_data, eMix);
            checkEq("bp ready low", 128'(b4.in_ready), 128'(0));
        end
        n = 0;
        while (!b1.out_valid && n < 30) begin
            @(negedge clk);
            n++;
        end
        checkEq("bp valid1 rise", 128'(b1.out_valid), 128'(1));
        checkEq("bp data16", b16.out_data, eMix);
        checkEq("bp data1", b1.out_data, eMix);
        xferBefore = xfer4;
        outReady = 1'b1;
        @(posedge clk);
        #1;
        checkEq("bp valid4 drop", 128'(b4.out_valid), 128'(0));
        checkEq("bp valid16 drop", 128'(b16.out_valid), 128'(0));
        checkEq("bp valid1 drop", 128'(b1.out_valid), 128'(0));
        checkEq("bp ready4 back", 128'(b4.in_ready), 128'(1));
        repeat (3) begin
            @(negedge clk);
            checkEq("bp no second", 128'(b4.out_valid), 128'(0));
        end
        checkEq("bp transfers", 128'(xfer4 - xferBefore), 128'(1));

        // Reset in the middle of RUN (LANES=4 counter at 2).
        sendWord(vInvB, 1'b0);
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        checkEq("mid busy4", 128'(busy4), 128'(1));
        checkEq("mid valid4", 128'(b4.out_valid), 128'(0));
        rstN = 1'b0;
        #1;
        checkEq("arst valid4", 128'(b4.out_valid), 128'(0));
        checkEq("arst data4", b4.out_data, 128'(0));
        checkEq("arst busy4", 128'(busy4), 128'(0));
        checkEq("arst ready4", 128'(b4.in_ready), 128'(0));
        checkEq("arst data16", b16.out_data, 128'(0));
        checkEq("arst data1", b1.out_data, 128'(0));
        repeat (2) @(negedge clk);
        rstN = 1'b1;
        @(posedge clk);
        #1;
        checkEq("post rst ready4", 128'(b4.in_ready), 128'(1));
        sendWord(vMix, 1'b0);
        collectWord(eMix, "post-reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/sub_bytes_engine.md
Name: sub_bytes_engine

Overview:
- Multi-cycle AES SubBytes unit that processes one WORD_BYTES-wide word per transaction, substituting LANES bytes per clock through replicated S-box lookups.
- Supports forward and inverse substitution, selectable per transaction.
- Sits between the round-state register and the ShiftRows/MixColumns stage.
- Uses a valid/ready handshake on both input and output.
- Trades area (LANES lookups) against latency (WORD_BYTES/LANES cycles).

Parameters:
- WORD_BYTES, 16: bytes per word. 16 is a full AES state; 4 is a key-schedule word.
- LANES, 4: S-box lookups per cycle. Must divide WORD_BYTES; elaboration fails otherwise.
- NCHUNK, WORD_BYTES/LANES: derived localparam, not overridable.

Ports:
- clk  in  1  clock, rising-edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input word present.
- in_ready  out  1  engine can accept a word.
- in_data  in  8*WORD_BYTES  word. Byte i is in_data[8i+7:8i].
- in_inv  in  1  1 = inverse S-box, 0 = forward. Sampled with in_data.
- out_valid  out  1  result available.
- out_ready  in  1  consumer accepts the result.
- out_data  out  8*WORD_BYTES  substituted word, same byte order as in_data.
- busy  out  1  high in RUN or DONE.

Behaviour:
- Reset (async assert, sync release): state IDLE, chunk counter 0, result register 0, latched inv 0.
  - Outputs during reset: out_valid=0, out_data=0, busy=0, in_ready=0.
- States:
  - IDLE: in_ready=1.
    - When in_valid&&in_ready: latch in_data and in_inv, counter=0, go to RUN.
    - in_data is ignored when in_valid=0.
  - RUN: in_ready=0.
    - Each cycle, bytes cnt*LANES .. cnt*LANES+LANES-1 of the latched word are substituted and written to the same byte positions of the result register.
    - cnt increments each cycle. When cnt==NCHUNK-1, the write completes and the state goes to DONE.
  - DONE: out_valid=1; out_data is held stable.
    - When out_ready=1, go to IDLE. out_valid drops on the next edge.
- in_ready is a decode of state==IDLE. There is no same-cycle DONE-to-accept overlap.
- Latency: the accept edge is cycle 0; out_valid rises after edge NCHUNK.
  - Minimum throughput: one word per NCHUNK+2 cycles with out_ready tied high.
  - NCHUNK=1 (LANES==WORD_BYTES): RUN lasts exactly one cycle.
- Backpressure: DONE holds indefinitely; out_data and out_valid are stable while out_ready=0.
- in_data and in_inv changes after acceptance have no effect on the running transaction.
- Reset asserted mid-RUN or mid-DONE: the transaction is discarded, outputs return to reset values, and no partial word is ever presented.
- S-box contents are the FIPS-197 forward and inverse tables, as pure combinational byte lookups.
- The counter is $clog2(NCHUNK) bits wide, minimum 1, with no wrap beyond NCHUNK-1.

Optional Feature:
- Macro: SBOX_INV_EN.
- Defined: the inverse table is instantiated in every lane, and in_inv selects the table per transaction.
- Undefined:
  - Only the forward table is built.
  - in_inv is ignored; it remains a port so the interface is unchanged.
  - The latched inv bit is removed, and every transaction applies the forward S-box.

Decomposition:
- Package aes_sbox_pkg:
  - 256-entry forward and inverse S-box constant arrays.
  - State enum {IDLE, RUN, DONE}.
  - A byte typedef.
- Sub-module sbox_lut: one-byte combinational lookup.
  - Ports: byte_in, inv, byte_out.
  - Inverse path only under SBOX_INV_EN.
  - Instantiated LANES times in a generate loop, indexed by the chunk counter.

Test Plan:
- Single byte checks (WORD_BYTES=16, LANES=4, out_ready=1):
  - in_data all 0x00, in_inv=0 -> out_data all 0x63.
  - out_valid first high 4 cycles after the accept edge.
  - in_ready back high the cycle after the DONE handshake.
- Mixed bytes: byte0=0x53, byte1=0x00, byte15=0xff, others 0x01 -> byte0=0xed, byte1=0x63, byte15=0x16, others 0x7c.
- Inverse (SBOX_INV_EN defined): in_inv=1, all bytes 0x63 -> all 0x00; byte0=0xed -> 0x53.
  - Without the macro, the same stimulus -> all bytes 0xfb.
- Backpressure: out_ready=0 for 10 cycles after out_valid rises.
  - out_valid and out_data stay stable, and in_ready stays 0.
  - Releasing out_ready -> exactly one transfer.
- Reset mid-RUN: assert rst_n=0 at cnt=2.
  - out_valid=0 and out_data=0 immediately (async).
  - After release, in_ready=1, and a fresh word completes correctly.
- Parameter sweep: LANES=16 and LANES=1 with WORD_BYTES=16.
  - Latency is 1 and 16 cycles respectively, with results identical to the LANES=4 run.
